// File: rtl/exe_mem_skid_stage.sv
// ============================================================================
// exe_mem_skid_stage : EXE->MEM boundary register with registered ready and a one-entry skid buffer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module exe_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int DST_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [DST_W-1:0]  in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DST_W-1:0]  out_dst,
  output logic [1:0]        occupancy
);

  localparam int ENT_W = 3 + 2 * DATA_W + DST_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [ENT_W-1:0]   main_q, main_d;
  logic [ENT_W-1:0]   skid_q, skid_d;
  logic               w_in_fire, w_out_fire;
  logic [ENT_W-1:0]   w_in_entry;

  assign w_in_entry = {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_res, in_val_rm, in_dst};
  assign out_valid  = (state_q != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready_q;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    in_ready_d = in_ready_q;
    if (flush) begin
      // Squash both entries; data registers keep their stale contents.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_in_fire) begin
            main_d  = w_in_entry;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            main_d = w_in_entry;
          end else if (w_in_fire) begin
            skid_d  = w_in_entry;
            state_d = S_TWO;
          end else if (w_out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // Ready is a pure function of the next state, so it never sees out_ready combinationally.
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_wb_en    = main_q[ENT_W-1] & out_valid;
  assign out_mem_r_en = main_q[ENT_W-2] & out_valid;
  assign out_mem_w_en = main_q[ENT_W-3] & out_valid;
  assign out_alu_res  = main_q[2*DATA_W+DST_W-1 -: DATA_W];
  assign out_val_rm   = main_q[DATA_W+DST_W-1 -: DATA_W];
  assign out_dst      = main_q[DST_W-1:0];
  assign occupancy    = (state_q == S_TWO) ? 2'd2 : (state_q == S_ONE) ? 2'd1 : 2'd0;

endmodule

`default_nettype wire

// File: tb/tb_exe_mem_skid_stage.sv
// Directed and randomised checks of exe_mem_skid_stage with DATA_W=64, DST_W=5.
`default_nettype none

module tb_exe_mem_skid_stage;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic          in_wb_en, in_mem_r_en, in_mem_w_en;
  logic [DW-1:0] in_alu_res, in_val_rm;
  logic [AW-1:0] in_dst;
  logic          out_valid, out_ready, out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [DW-1:0] out_alu_res, out_val_rm;
  logic [AW-1:0] out_dst;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  exe_mem_skid_stage #(.DATA_W(DW), .DST_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_alu_res(in_alu_res), .in_val_rm(in_val_rm), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
    .out_alu_res(out_alu_res), .out_val_rm(out_val_rm), .out_dst(out_dst),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rm, input logic [AW-1:0] d);
    in_valid = v; in_wb_en = wb; in_mem_r_en = mr; in_mem_w_en = mw;
    in_alu_res = alu; in_val_rm = rm; in_dst = d;
  endtask

  logic [136-1:0] q[$];
  logic [136-1:0] head, exp_e;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", {out_wb_en, out_mem_r_en, out_mem_w_en}, 0);
    check("rst_data", {out_alu_res, out_val_rm, out_dst}, 0);
    check("rst_occ", occupancy, 0);
    check("rst_ready", in_ready, 1);

    // First transaction, latency one cycle
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 5'd3);
    tick();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_alu", out_alu_res, 64'h10);
    check("t1_dst", out_dst, 3);
    check("t1_wb", out_wb_en, 1);
    check("t1_occ", occupancy, 1);
    tick();
    check("t1_drain_occ", occupancy, 0);

    // Eight back-to-back beats with out_ready high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h100 + 64'(i), 64'h0, 5'(i));
      tick();
      check("str_ready", in_ready, 1);
      check("str_valid", out_valid, 1);
      check("str_alu", out_alu_res, 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check("str_end_occ", occupancy, 0);

    // Back-pressure fills the skid; release drains in order
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'hA, 64'h0, 5'd1);
    tick();
    check("bp_occ1", occupancy, 1);
    check("bp_ready1", in_ready, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'hB, 64'h5, 5'd2);
    tick();
    in_valid = 1'b0;
    check("bp_occ2", occupancy, 2);
    check("bp_ready2", in_ready, 0);
    check("bp_headA", out_alu_res, 64'hA);
    check("bp_A_ctrl", {out_mem_r_en, out_mem_w_en}, 2'b10);
    out_ready = 1'b1;
    tick();
    check("bp_headB", out_alu_res, 64'hB);
    check("bp_B_w", out_mem_w_en, 1);
    check("bp_ready_back", in_ready, 1);
    check("bp_occ_back", occupancy, 1);
    tick();
    check("bp_empty", occupancy, 0);
    check("bp_bubble_w", out_mem_w_en, 0);

    // Flush while full
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'hC, 64'h1, 5'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'hD, 64'h2, 5'd5);
    tick();
    in_valid = 1'b0;
    check("fl_occ2", occupancy, 2);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_occ", occupancy, 0);
    check("fl_valid", out_valid, 0);
    check("fl_w", out_mem_w_en, 0);
    check("fl_ready", in_ready, 1);

    // Reset while full with a pending input
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hE, 64'h3, 5'd6);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hF, 64'h4, 5'd7);
    tick();
    check("mr_occ2", occupancy, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h77, 64'h88, 5'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mr_outs", {out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_res, out_val_rm, out_dst}, 0);
    check("mr_occ", occupancy, 0);
    check("mr_ready", in_ready, 1);
    tick();
    check("mr_not_captured", out_valid, 0);

    // Random traffic against an in-order queue model
    q.delete();
    in_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!in_valid) begin
        if ($urandom_range(1) == 1)
          drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
      end
      out_ready = 1'($urandom);
      #1;
      if (!out_valid)
        check("rnd_gate", {out_wb_en, out_mem_r_en, out_mem_w_en}, 0);
      check("rnd_occ", occupancy, 160'(q.size()));
      head = {out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_res, out_val_rm, out_dst};
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_extra_beat", 1, 0);
        else begin
          exp_e = q.pop_front();
          check("rnd_beat", head, exp_e);
        end
      end
      if (in_valid && in_ready)
        q.push_back({in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_res, in_val_rm, in_dst});
      tick();
      if (in_valid && q.size() > 0 && in_ready !== 1'bx) begin
        // Drop in_valid once the beat that was offered has been accepted.
        if (q[$] == {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_res, in_val_rm, in_dst})
          in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4 && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        exp_e = q.pop_front();
        check("drain_beat", {out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_res, out_val_rm, out_dst}, exp_e);
      end
      tick();
    end
    check("drain_empty", 160'(q.size()), 0);
    check("drain_occ", occupancy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
